// File: rtl/viol_rst_if.sv
// Bus between the violation monitors/core and the violation reset controller.
// master = core/monitor side, slave = controller.
interface viol_rst_if #(
  parameter int unsigned N_SRC = 4,
  parameter int unsigned CNT_W = 8
);
  logic [15:0]      pc;
  logic [N_SRC-1:0] viol_req;
  logic             cause_clr;
  logic             sys_rst;
  logic [N_SRC-1:0] cause;
  logic [CNT_W-1:0] viol_cnt;
  logic             rst_busy;

  modport master (
    output pc, viol_req, cause_clr,
    input  sys_rst, cause, viol_cnt, rst_busy
  );

  modport slave (
    input  pc, viol_req, cause_clr,
    output sys_rst, cause, viol_cnt, rst_busy
  );
endinterface

// File: rtl/viol_rst_ctrl.sv
// Aggregates monitor violation requests into a registered core reset with a
// minimum pulse width, PC-gated release, sticky cause bits and episode count.
module viol_rst_ctrl #(
  parameter int unsigned N_SRC         = 4,
  parameter int unsigned MIN_PULSE     = 8,
  parameter logic [15:0] RESET_HANDLER = 16'h0000,
  parameter int unsigned CNT_W         = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  viol_rst_if.slave   bus
);

  localparam int unsigned PW = (MIN_PULSE > 1) ? $clog2(MIN_PULSE) : 1;
  localparam logic [PW-1:0] RELOAD = PW'(MIN_PULSE - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    HOLD    = 2'b01,
    RELEASE = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    cnt_q, cnt_d;
  logic [N_SRC-1:0] cause_q, cause_d;
  logic [CNT_W-1:0] vcnt_q, vcnt_d;
  logic             sys_rst_q, sys_rst_d;
  logic             any_req;

  assign any_req = |bus.viol_req;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    vcnt_d  = vcnt_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          // A simultaneous clear is applied before the new episode is recorded.
          state_d = HOLD;
          cnt_d   = RELOAD;
          if (bus.cause_clr) begin
            cause_d = bus.viol_req;
            vcnt_d  = CNT_W'(1);
          end else begin
            cause_d = cause_q | bus.viol_req;
            vcnt_d  = (vcnt_q == '1) ? vcnt_q : vcnt_q + 1'b1;
          end
        end else if (bus.cause_clr) begin
          cause_d = '0;
          vcnt_d  = '0;
        end
      end
      HOLD: begin
        if (any_req) begin
          cnt_d   = RELOAD;
          cause_d = cause_q | bus.viol_req;
        end else if (cnt_q == '0) begin
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RELEASE: begin
        if (any_req) begin
          state_d = HOLD;
          cnt_d   = RELOAD;
          cause_d = cause_q | bus.viol_req;
        end else if (bus.pc == RESET_HANDLER) begin
          state_d = IDLE;
        end
      end
      default: begin
        // Unreachable encoding: fail safe into a fresh reset pulse.
        state_d = HOLD;
        cnt_d   = RELOAD;
        cause_d = cause_q | bus.viol_req;
      end
    endcase
    sys_rst_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cause_q   <= '0;
      vcnt_q    <= '0;
      sys_rst_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cause_q   <= cause_d;
      vcnt_q    <= vcnt_d;
      sys_rst_q <= sys_rst_d;
    end
  end

  assign bus.sys_rst  = sys_rst_q;
  assign bus.rst_busy = sys_rst_q;
  assign bus.cause    = cause_q;
  assign bus.viol_cnt = vcnt_q;

endmodule

// File: tb/tb_viol_rst_ctrl.sv
// Directed plus randomized bench for viol_rst_ctrl against a quiet-cycle
// based reference model of the reset/cause/episode rules.
module tb_viol_rst_ctrl;
  localparam int unsigned N_SRC     = 4;
  localparam int unsigned MIN_PULSE = 8;
  localparam int unsigned CNT_W     = 8;
  localparam logic [15:0] RH        = 16'h0000;
  localparam int          EPS_MAX   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  viol_rst_if #(.N_SRC(N_SRC), .CNT_W(CNT_W)) bus();

  viol_rst_ctrl #(
    .N_SRC(N_SRC),
    .MIN_PULSE(MIN_PULSE),
    .RESET_HANDLER(RH),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: in reset or not, edges since the last request, sticky cause, episodes.
  int         m_rst;
  int         m_quiet;
  int         m_eps;
  logic [3:0] m_cause;

  task automatic model_reset();
    m_rst = 0; m_quiet = 0; m_eps = 0; m_cause = '0;
  endtask

  task automatic model_edge(input logic [3:0] req, input logic [15:0] pc, input logic clr);
    if (req != 4'b0) begin
      if (m_rst == 0) begin
        if (clr) begin
          m_cause = '0;
          m_eps   = 0;
        end
        m_eps = (m_eps < EPS_MAX) ? m_eps + 1 : EPS_MAX;
      end
      m_cause = m_cause | req;
      m_rst   = 1;
      m_quiet = 0;
    end else if (m_rst != 0) begin
      if (m_quiet >= int'(MIN_PULSE) && pc == RH) m_rst = 0;
      else if (m_quiet < int'(MIN_PULSE)) m_quiet++;
    end else if (clr) begin
      m_cause = '0;
      m_eps   = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("sys_rst",  32'(bus.sys_rst),  32'(m_rst));
    chk("rst_busy", 32'(bus.rst_busy), 32'(m_rst));
    chk("cause",    32'(bus.cause),    32'(m_cause));
    chk("viol_cnt", 32'(bus.viol_cnt), 32'(m_eps));
  endtask

  // Called just after a falling edge; drives, clocks, then checks on the next falling edge.
  task automatic cycle(input logic [3:0] req, input logic [15:0] pc, input logic clr);
    bus.viol_req  = req;
    bus.pc        = pc;
    bus.cause_clr = clr;
    @(posedge clk);
    if (reset_n) model_edge(req, pc, clr);
    else model_reset();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_out();
    for (int i = 0; i < 40 && bus.sys_rst !== 1'b0; i++) cycle(4'b0, RH, 1'b0);
    chk("idle_out", 32'(bus.sys_rst), 32'(0));
  endtask

  initial begin
    int hi;
    model_reset();
    bus.viol_req  = 4'b1111;
    bus.pc        = RH;
    bus.cause_clr = 1'b0;
    @(negedge clk);

    // Reset held with all requests active
    repeat (3) cycle(4'b1111, RH, 1'b0);
    reset_n = 1'b1;
    cycle(4'b1111, RH, 1'b0);
    chk("post_reset_cause", 32'(bus.cause), 32'hF);
    chk("post_reset_cnt", 32'(bus.viol_cnt), 32'd1);
    idle_out();
    cycle(4'b0, RH, 1'b1);

    // Single-cycle pulse with PC at the handler
    cycle(4'b0001, RH, 1'b0);
    hi = 1;
    for (int i = 0; i < 40 && bus.sys_rst === 1'b1; i++) begin
      cycle(4'b0, RH, 1'b0);
      if (bus.sys_rst === 1'b1) hi++;
    end
    chk("pulse_len", 32'(hi), 32'(MIN_PULSE + 1));
    cycle(4'b0, RH, 1'b1);

    // Extension and OR of causes, PC gating the release
    for (int c = 0; c < 40; c++) begin
      logic [3:0] r;
      r = (c == 0) ? 4'b0001 : (c == 5) ? 4'b0100 : 4'b0000;
      cycle(r, (c <= 30) ? 16'hE010 : RH, 1'b0);
      if (c == 30) chk("ext_still_rst", 32'(bus.sys_rst), 32'd1);
      if (c == 31) chk("ext_released", 32'(bus.sys_rst), 32'd0);
    end
    chk("ext_cause", 32'(bus.cause), 32'h5);
    chk("ext_cnt", 32'(bus.viol_cnt), 32'd1);

    // Re-trigger in RELEASE on the same cycle the PC reaches the handler
    cycle(4'b0001, 16'hE010, 1'b0);
    repeat (10) cycle(4'b0, 16'hE010, 1'b0);
    cycle(4'b1000, RH, 1'b0);
    hi = 1;
    for (int i = 0; i < 40 && bus.sys_rst === 1'b1; i++) begin
      cycle(4'b0, RH, 1'b0);
      if (bus.sys_rst === 1'b1) hi++;
    end
    chk("retrig_len", 32'(hi), 32'(MIN_PULSE + 1));
    chk("retrig_cnt", 32'(bus.viol_cnt), 32'd2);

    // cause_clr ignored in HOLD, honoured in IDLE, clear-then-request ordering
    cycle(4'b0100, 16'hE010, 1'b0);
    cycle(4'b0000, 16'hE010, 1'b1);
    chk("clr_in_hold", 32'(bus.viol_cnt), 32'd3);
    idle_out();
    cycle(4'b0000, RH, 1'b1);
    chk("clr_idle_cnt", 32'(bus.viol_cnt), 32'd0);
    cycle(4'b0010, RH, 1'b1);
    chk("clr_req_cause", 32'(bus.cause), 32'h2);
    chk("clr_req_cnt", 32'(bus.viol_cnt), 32'd1);
    idle_out();
    cycle(4'b0000, RH, 1'b1);

    // Counter saturation over 260 episodes
    for (int e = 0; e < 260; e++) begin
      cycle(4'b0001 << (e % 4), RH, 1'b0);
      repeat (MIN_PULSE + 1) cycle(4'b0, RH, 1'b0);
    end
    chk("saturated", 32'(bus.viol_cnt), 32'd255);
    cycle(4'b0000, RH, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [3:0]  r;
      logic [15:0] p;
      r = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'b0;
      p = ($urandom_range(0, 1) == 0) ? RH : 16'($urandom);
      cycle(r, p, ($urandom_range(0, 7) == 0));
    end

    // Asynchronous reset in the middle of HOLD
    cycle(4'b0011, 16'hE010, 1'b0);
    cycle(4'b0000, 16'hE010, 1'b0);
    #2 reset_n = 1'b0;
    #1 model_reset();
    check_all();
    chk("async_before_edge", 32'(clk), 32'd0);
    #10 reset_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/viol_rst_ctrl.md
Name: viol_rst_ctrl

Overview:
Downstream of the per-property hardware monitors (stack/key/atomicity checkers). Each monitor raises a combinational violation-reset request. This block aggregates the requests into one registered system reset for the MSP430 core and holds it for at least MIN_PULSE cycles. It then keeps reset asserted until the core PC reaches the reset handler with no violation pending, and records sticky cause bits plus a saturating violation-episode counter for post-reset diagnostics.

Parameters:
N_SRC, 4, number of monitor request inputs (1..16)
MIN_PULSE, 8, minimum sys_rst high time in clk cycles after the last request (>=1)
RESET_HANDLER, 16'h0000, PC value that permits release
CNT_W, 8, width of the violation-episode counter

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
pc  input  16  current core program counter
viol_req  input  N_SRC  per-monitor violation reset requests, active high, level
cause_clr  input  1  clear cause and viol_cnt (honoured in IDLE only)
sys_rst  output  1  registered reset to core, active high
cause  output  N_SRC  sticky OR of all requests seen since last clear
viol_cnt  output  CNT_W  number of violation episodes since last clear, saturating
rst_busy  output  1  high whenever state != IDLE

Behaviour:
- Async reset (reset_n=0):
  - state=IDLE; sys_rst=0, cause=0, viol_cnt=0, rst_busy=0; pulse counter=0.
  - Deassertion is sampled normally on the next clk edge; no request is lost if viol_req is high at deassertion.
- any_req = OR of viol_req.
- Pulse counter is ceil(log2(MIN_PULSE)) bits, minimum 1.
- States, with encoding:
  - IDLE=2'b00
  - HOLD=2'b01
  - RELEASE=2'b10
  - 2'b11 is illegal and returns to HOLD with a counter reload, failing safe to reset.
- IDLE:
  - On any_req: go to HOLD, pulse counter <= MIN_PULSE-1, cause <= cause|viol_req, viol_cnt <= viol_cnt+1 (saturating at all-ones).
  - Else, if cause_clr: cause <= 0, viol_cnt <= 0.
  - If any_req and cause_clr occur in the same cycle: clear first, then apply the request. Result is cause=viol_req, viol_cnt=1.
- HOLD:
  - If any_req: reload counter to MIN_PULSE-1 and cause |= viol_req. viol_cnt is not incremented, because it counts episodes, not cycles.
  - Else if counter==0: go to RELEASE.
  - Else: counter decrements.
- RELEASE:
  - If any_req: go to HOLD, reload counter, cause |= viol_req.
  - Else if pc==RESET_HANDLER: go to IDLE.
  - Else: stay.
- Outputs:
  - sys_rst = 1 in HOLD and RELEASE, registered from next-state.
  - rst_busy = sys_rst.
- Latency:
  - any_req sampled high at edge k gives sys_rst=1 immediately after edge k (1-cycle request-to-reset).
  - Release: pc==RESET_HANDLER sampled at edge j gives sys_rst=0 after edge j.
- Minimum pulse: with a single-cycle request at edge k and pc already at RESET_HANDLER, sys_rst stays high for exactly MIN_PULSE+1 cycles (HOLD for MIN_PULSE, RELEASE for 1).
- cause_clr is ignored in HOLD and RELEASE, so cause cannot be erased while reset is active.
- viol_cnt saturates at 2^CNT_W-1 and never wraps.
- A request reasserting in the same cycle as release takes priority: the block stays in reset and goes to HOLD.

Test Plan:
- Reset: hold reset_n=0 with viol_req=4'b1111 -> sys_rst=0, cause=0, viol_cnt=0. After release, next edge -> sys_rst=1, cause=4'b1111, viol_cnt=1.
- Single pulse, MIN_PULSE=8, pc=16'h0000: viol_req=4'b0001 for 1 cycle -> sys_rst high for exactly 9 cycles, cause=4'b0001, viol_cnt=1, then IDLE.
- Extension and OR: req[0] at cycle 0, req[2] at cycle 5, pc=16'hE010 until cycle 30 then 16'h0000 -> sys_rst low only after pc==16'h0000 is sampled; HOLD has run ≥8 cycles after cycle 5; cause=4'b0101, viol_cnt=1.
- Re-trigger in RELEASE: in RELEASE, req[3] high in the same cycle pc==16'h0000 -> state HOLD, counter reloaded to 7, sys_rst stays 1, viol_cnt unchanged.
- cause_clr: asserted in HOLD -> no effect. Asserted in IDLE -> cause=0, viol_cnt=0. Asserted with req[1] in IDLE -> cause=4'b0010, viol_cnt=1.
- Saturation: CNT_W=8, 260 separate episodes -> viol_cnt=255. Async reset_n low mid-HOLD -> sys_rst=0 and state IDLE immediately, without waiting for a clk edge.
